// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
//   - state_e     : 3-bit loader state encoding
//   - CNT_W       : width of the word-count field at the head of the stream
//   - chk_update  : running XOR checksum step
package prog_loader_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_CNT_HI = 3'd0,
        S_CNT_LO = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_CHECK  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    // One step of the 8-bit XOR checksum over the accepted stream bytes.
    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and status of the loader.
//   slave  : the loader side (consumes bytes, produces writes/status)
//   master : the environment side (byte source, memory, core reset, status sink)
interface prog_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] imem_w_addr;
    logic [31:0] imem_w_data;
    logic        imem_w_ena;
    logic        cpu_reset_n;
    logic        done;
    logic        error;

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, imem_w_addr, imem_w_data, imem_w_ena,
               cpu_reset_n, done, error
    );

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, imem_w_addr, imem_w_data, imem_w_ena,
               cpu_reset_n, done, error
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// byte_packer: assembles four stream bytes, most significant first, into a
// 32-bit word.
//   clock, reset : clock and asynchronous active-low reset
//   shift_en     : shift byte_in into the assembly register this cycle
//   byte_in      : data byte
//   word_out     : assembly register contents (complete after the 4th shift)
//   word_last    : the next shift completes a word
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_last
);

    logic [31:0] asm_r;
    logic [1:0]  cnt_r;

    // Shift register and byte-position counter; the counter wraps every word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            asm_r <= 32'd0;
            cnt_r <= 2'd0;
        end else if (shift_en) begin
            asm_r <= {asm_r[23:0], byte_in};
            cnt_r <= cnt_r + 2'd1;
        end else begin
            asm_r <= asm_r;
            cnt_r <= cnt_r;
        end
    end

    assign word_out  = asm_r;
    assign word_last = (cnt_r == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: receives a program over a byte stream and writes it into
// instruction memory while holding the processor in reset.
// Stream: count N (16 bit, high byte first), N words (MSB first), checksum
// byte equal to the XOR of every preceding byte.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : byte stream in, imem write port, cpu_reset_n/done/error out
// A load that is too long or carries a bad checksum ends in a terminal error
// state; the core stays held in reset until the next reset.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 32'd256
) (
    input logic          clock,
    input logic          reset,
    prog_loader_if.slave bus
);

    state_e           state_r;
    state_e           state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] idx_r;
    logic [CNT_W-1:0] n_s;
    logic [7:0]       chk_r;
    logic             accept_s;
    logic             shift_s;
    logic             ready_nx_s;
    logic             byte_ready_r;
    logic             ena_r;
    logic             done_r;
    logic             error_r;
    logic             cpu_rst_n_r;
    logic [31:0]      word_s;
    logic             word_last_s;

    assign accept_s = bus.byte_valid & byte_ready_r;
    // Full count as it will be once the low byte lands.
    assign n_s      = {cnt_r[CNT_W-1 -: 8], bus.byte_in};

    byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .shift_en  (shift_s),
        .byte_in   (bus.byte_in),
        .word_out  (word_s),
        .word_last (word_last_s)
    );

    // Next-state decode and packer shift control.
    always_comb begin
        state_nx_s = state_r;
        shift_s    = 1'b0;
        case (state_r)
            S_CNT_HI: begin
                if (accept_s) begin
                    state_nx_s = S_CNT_LO;
                end else begin
                    state_nx_s = state_r;
                end
            end
            S_CNT_LO: begin
                if (!accept_s) begin
                    state_nx_s = state_r;
                end else if ({{(32-CNT_W){1'b0}}, n_s} > MAX_WORDS) begin
                    state_nx_s = S_ERROR;
                end else if (n_s == 16'd0) begin
                    state_nx_s = S_CHECK;
                end else begin
                    state_nx_s = S_DATA;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    shift_s = 1'b1;
                    if (word_last_s) begin
                        state_nx_s = S_WRITE;
                    end else begin
                        state_nx_s = S_DATA;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            S_WRITE: begin
                if (idx_r == cnt_r - 16'd1) begin
                    state_nx_s = S_CHECK;
                end else begin
                    state_nx_s = S_DATA;
                end
            end
            S_CHECK: begin
                if (!accept_s) begin
                    state_nx_s = state_r;
                end else if (bus.byte_in == chk_r) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_ERROR;
                end
            end
            S_DONE:  state_nx_s = S_DONE;
            S_ERROR: state_nx_s = S_ERROR;
            // An illegal encoding fails safe: the core stays held.
            default: state_nx_s = S_ERROR;
        endcase
    end

    // Ready is decoded from the next state so the registered copy lines up
    // with the state it belongs to.
    always_comb begin
        ready_nx_s = 1'b0;
        case (state_nx_s)
            S_CNT_HI, S_CNT_LO, S_DATA, S_CHECK: ready_nx_s = 1'b1;
            default:                            ready_nx_s = 1'b0;
        endcase
    end

    // State register plus registered status/strobe outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= S_CNT_HI;
            byte_ready_r <= 1'b1;
            ena_r        <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            cpu_rst_n_r  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            byte_ready_r <= ready_nx_s;
            ena_r        <= (state_nx_s == S_WRITE);
            done_r       <= (state_nx_s == S_DONE);
            error_r      <= (state_nx_s == S_ERROR);
            cpu_rst_n_r  <= (state_nx_s == S_DONE);
        end
    end

    // Word count capture: high byte first, then the full 16-bit value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r <= 16'd0;
        end else if (state_r == S_CNT_HI && accept_s) begin
            cnt_r <= {bus.byte_in, 8'd0};
        end else if (state_r == S_CNT_LO && accept_s) begin
            cnt_r <= n_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Running checksum over count and data bytes (not the checksum byte).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            chk_r <= 8'd0;
        end else if (accept_s && (state_r == S_CNT_HI || state_r == S_CNT_LO ||
                                  state_r == S_DATA)) begin
            chk_r <= chk_update(chk_r, bus.byte_in);
        end else begin
            chk_r <= chk_r;
        end
    end

    // Word index; it doubles as the write address during the write cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_r <= 16'd0;
        end else if (state_r == S_WRITE) begin
            idx_r <= idx_r + 16'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    assign bus.byte_ready  = byte_ready_r;
    assign bus.imem_w_ena  = ena_r;
    assign bus.imem_w_addr = {{(32-CNT_W){1'b0}}, idx_r};
    assign bus.imem_w_data = word_s;
    assign bus.done        = done_r;
    assign bus.error       = error_r;
    assign bus.cpu_reset_n = cpu_rst_n_r;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed streams plus randomized loads,
// checked against a stream-level reference model.
module tb_prog_loader;

    localparam int MAXW = 256;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    prog_loader_if bus();

    prog_loader #(.MAX_WORDS(MAXW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  stim[$];
    logic [63:0] got_wr[$];
    logic [63:0] exp_wr[$];
    logic        exp_done;
    logic        exp_err;

    // Capture every write strobe; the loader must not accept bytes while writing.
    always @(negedge clock) begin
        if (bus.imem_w_ena === 1'b1) begin
            got_wr.push_back({bus.imem_w_addr, bus.imem_w_data});
            total++;
            if (bus.byte_ready !== 1'b0) begin
                bad++;
                $display("FAIL ready_in_write: byte_ready=%b required 0", bus.byte_ready);
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: parse the stream by its rules and list the expected outcome.
    task automatic model_stream();
        int          n;
        logic [7:0]  x;
        exp_wr.delete();
        n = int'({stim[0], stim[1]});
        if (n > MAXW) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        x = 8'd0;
        for (int i = 0; i < 2 + 4 * n; i++) x = x ^ stim[i];
        for (int w = 0; w < n; w++)
            exp_wr.push_back({32'(w), stim[2+4*w], stim[3+4*w], stim[4+4*w], stim[5+4*w]});
        exp_done = (stim[2 + 4 * n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset          = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'd0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        got_wr.delete();
    endtask

    // Send stim with 0..max_gap idle cycles (random junk on byte_in) before each byte.
    task automatic send(input int max_gap);
        int gap;
        int waits;
        foreach (stim[i]) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                @(negedge clock);
                bus.byte_valid = 1'b0;
                bus.byte_in    = 8'($urandom);
            end
            @(negedge clock);
            bus.byte_valid = 1'b1;
            bus.byte_in    = stim[i];
            waits = 0;
            while (bus.byte_ready !== 1'b1 && waits < 50) begin
                @(negedge clock);
                waits++;
            end
            if (waits >= 50) begin
                total++;
                bad++;
                $display("FAIL send_timeout: byte %0d not accepted after %0d cycles, required acceptance", i, waits);
                bus.byte_valid = 1'b0;
                return;
            end
            @(posedge clock);
        end
        @(negedge clock);
        bus.byte_valid = 1'b0;
    endtask

    task automatic set_two_word(input logic [7:0] last);
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                 8'h00, 8'h00, 8'h00, 8'h00, last};
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        total += 7;
        if (bus.imem_w_ena !== 1'b0) begin bad++; $display("FAIL rst_ena: got %b required 0", bus.imem_w_ena); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b required 0", bus.done); end
        if (bus.error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b required 0", bus.error); end
        if (bus.cpu_reset_n !== 1'b0) begin bad++; $display("FAIL rst_cpu: got %b required 0", bus.cpu_reset_n); end
        if (bus.imem_w_addr !== 32'd0) begin bad++; $display("FAIL rst_addr: got %h required 0", bus.imem_w_addr); end
        if (bus.imem_w_data !== 32'd0) begin bad++; $display("FAIL rst_data: got %h required 0", bus.imem_w_data); end
        if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b required 1", bus.byte_ready); end
    endtask

    task automatic test_two_word();
        do_reset();
        set_two_word(8'h2F);
        send(0);
        repeat (2) @(negedge clock);
        total += 6;
        if (got_wr.size() !== 2) begin
            bad++; $display("FAIL two_word_count: got %0d writes required 2", got_wr.size());
        end else begin
            if (got_wr[0] !== {32'd0, 32'h20080005}) begin bad++; $display("FAIL two_word_w0: got %h required 0000000020080005", got_wr[0]); end
            if (got_wr[1] !== {32'd1, 32'h00000000}) begin bad++; $display("FAIL two_word_w1: got %h required 0000000100000000", got_wr[1]); end
        end
        if (bus.done !== 1'b1) begin bad++; $display("FAIL two_word_done: got %b required 1", bus.done); end
        if (bus.cpu_reset_n !== 1'b1) begin bad++; $display("FAIL two_word_cpu: got %b required 1", bus.cpu_reset_n); end
        if (bus.error !== 1'b0) begin bad++; $display("FAIL two_word_error: got %b required 0", bus.error); end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        set_two_word(8'h2E);
        model_stream();
        send(0);
        repeat (2) @(negedge clock);
        total += 4;
        if (got_wr.size() !== exp_wr.size()) begin
            bad++; $display("FAIL badchk_count: got %0d writes required %0d", got_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i])
                if (got_wr[i] !== exp_wr[i]) begin bad++; $display("FAIL badchk_w%0d: got %h required %h", i, got_wr[i], exp_wr[i]); end
        end
        if (bus.error !== 1'b1) begin bad++; $display("FAIL badchk_error: got %b required 1", bus.error); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL badchk_done: got %b required 0", bus.done); end
        if (bus.cpu_reset_n !== 1'b0) begin bad++; $display("FAIL badchk_cpu: got %b required 0", bus.cpu_reset_n); end
    endtask

    task automatic test_empty();
        do_reset();
        stim = '{8'h00, 8'h00, 8'h00};
        send(0);
        repeat (2) @(negedge clock);
        total += 3;
        if (got_wr.size() !== 0) begin bad++; $display("FAIL empty_writes: got %0d required 0", got_wr.size()); end
        if (bus.done !== 1'b1) begin bad++; $display("FAIL empty_done: got %b required 1", bus.done); end
        if (bus.cpu_reset_n !== 1'b1) begin bad++; $display("FAIL empty_cpu: got %b required 1", bus.cpu_reset_n); end
    endtask

    task automatic test_oversize();
        do_reset();
        stim = '{8'h01, 8'h2C};
        send(0);
        // first sample after the 2nd byte's edge
        total += 3;
        if (bus.error !== 1'b1) begin bad++; $display("FAIL over_error: got %b required 1", bus.error); end
        if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL over_ready: got %b required 0", bus.byte_ready); end
        if (bus.done !== 1'b0) begin bad++; $display("FAIL over_done: got %b required 0", bus.done); end
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h55;
        repeat (4) @(negedge clock);
        bus.byte_valid = 1'b0;
        total += 3;
        if (got_wr.size() !== 0) begin bad++; $display("FAIL over_writes: got %0d required 0", got_wr.size()); end
        if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL over_ready_late: got %b required 0", bus.byte_ready); end
        if (bus.error !== 1'b1) begin bad++; $display("FAIL over_error_late: got %b required 1", bus.error); end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            set_two_word(8'h2F);
            model_stream();
            send(5);
            repeat (2) @(negedge clock);
            total += 3;
            if (got_wr.size() !== exp_wr.size()) begin
                bad++; $display("FAIL gaps_count r%0d: got %0d required %0d", r, got_wr.size(), exp_wr.size());
            end else begin
                foreach (exp_wr[i])
                    if (got_wr[i] !== exp_wr[i]) begin bad++; $display("FAIL gaps_w%0d r%0d: got %h required %h", i, r, got_wr[i], exp_wr[i]); end
            end
            if (bus.done !== 1'b1) begin bad++; $display("FAIL gaps_done r%0d: got %b required 1", r, bus.done); end
            if (bus.error !== 1'b0) begin bad++; $display("FAIL gaps_error r%0d: got %b required 0", r, bus.error); end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        stim = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        send(0);
        // asynchronous reset between edges, checked before the next edge
        #2 reset = 1'b0;
        #1;
        total += 6;
        if (bus.imem_w_ena !== 1'b0) begin bad++; $display("FAIL mid_ena: got %b required 0", bus.imem_w_ena); end
        if (bus.imem_w_addr !== 32'd0) begin bad++; $display("FAIL mid_addr: got %h required 0", bus.imem_w_addr); end
        if (bus.imem_w_data !== 32'd0) begin bad++; $display("FAIL mid_data: got %h required 0", bus.imem_w_data); end
        if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL mid_ready: got %b required 1", bus.byte_ready); end
        if (bus.cpu_reset_n !== 1'b0) begin bad++; $display("FAIL mid_cpu: got %b required 0", bus.cpu_reset_n); end
        if ((bus.done | bus.error) !== 1'b0) begin bad++; $display("FAIL mid_status: got done=%b error=%b required 0/0", bus.done, bus.error); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        got_wr.delete();
        set_two_word(8'h2F);
        model_stream();
        send(0);
        repeat (2) @(negedge clock);
        total += 2;
        if (got_wr.size() !== exp_wr.size()) begin
            bad++; $display("FAIL mid_resend_count: got %0d required %0d", got_wr.size(), exp_wr.size());
        end else begin
            foreach (exp_wr[i])
                if (got_wr[i] !== exp_wr[i]) begin bad++; $display("FAIL mid_resend_w%0d: got %h required %h", i, got_wr[i], exp_wr[i]); end
        end
        if (bus.done !== 1'b1) begin bad++; $display("FAIL mid_resend_done: got %b required 1", bus.done); end
    endtask

    task automatic test_random();
        int         n;
        int         kind;
        logic [7:0] x;
        for (int r = 0; r < 10; r++) begin
            do_reset();
            kind = int'($urandom_range(9, 0));
            if (kind == 0)      n = int'($urandom_range(65535, MAXW + 1));
            else if (kind == 1) n = 0;
            else if (kind == 2) n = MAXW;
            else                n = int'($urandom_range(7, 1));
            stim.delete();
            stim.push_back(8'(n >> 8));
            stim.push_back(8'(n));
            if (n <= MAXW) begin
                x = stim[0] ^ stim[1];
                for (int i = 0; i < 4 * n; i++) begin
                    stim.push_back(8'($urandom));
                    x = x ^ stim[stim.size() - 1];
                end
                stim.push_back(($urandom_range(3, 0) == 0) ? (x ^ 8'(1 << $urandom_range(7, 0))) : x);
            end
            model_stream();
            send((n > 16) ? 0 : 2);
            repeat (2) @(negedge clock);
            total += 4;
            if (got_wr.size() !== exp_wr.size()) begin
                bad++; $display("FAIL rand_count r%0d n=%0d: got %0d required %0d", r, n, got_wr.size(), exp_wr.size());
            end else begin
                foreach (exp_wr[i])
                    if (got_wr[i] !== exp_wr[i]) begin bad++; $display("FAIL rand_w%0d r%0d: got %h required %h", i, r, got_wr[i], exp_wr[i]); end
            end
            if (bus.done !== exp_done) begin bad++; $display("FAIL rand_done r%0d: got %b required %b", r, bus.done, exp_done); end
            if (bus.error !== exp_err) begin bad++; $display("FAIL rand_error r%0d: got %b required %b", r, bus.error, exp_err); end
            if (bus.cpu_reset_n !== exp_done) begin bad++; $display("FAIL rand_cpu r%0d: got %b required %b", r, bus.cpu_reset_n, exp_done); end
        end
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'd0;
        test_reset();
        test_two_word();
        test_bad_checksum();
        test_empty();
        test_oversize();
        test_gaps();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the largest accepted program length in 32-bit words.
REQ-002 SHALL have port clock  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port byte_in  input  8  incoming stream byte.
REQ-005 SHALL have port byte_valid  input  1  byte_in is valid this cycle.
REQ-006 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-007 SHALL have port imem_w_addr  output  32  instruction-memory word address.
REQ-008 SHALL have port imem_w_data  output  32  instruction word to write.
REQ-009 SHALL have port imem_w_ena  output  1  one-cycle instruction-memory write strobe.
REQ-010 SHALL have port cpu_reset_n  output  1  active-low hold for the processor core.
REQ-011 SHALL have port done  output  1  load completed and checksum matched.
REQ-012 SHALL have port error  output  1  load aborted.

Function
REQ-013 SHALL accept a byte only on a rising edge where byte_valid and byte_ready are both 1.
REQ-014 SHALL parse the stream in this order: a 16-bit word count N (high byte first), then N words of 4 bytes each (most significant byte first), then 1 checksum byte.
REQ-015 SHALL implement states S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CHECK, S_DONE and S_ERROR.
REQ-016 SHALL drive byte_ready=1 in S_CNT_HI, S_CNT_LO, S_DATA and S_CHECK, and byte_ready=0 in S_WRITE, S_DONE and S_ERROR.
REQ-017 SHALL go S_CNT_HI -> S_CNT_LO on an accepted byte.
REQ-018 SHALL, in S_CNT_LO on an accepted byte, go to S_ERROR if N > MAX_WORDS, to S_CHECK if N = 0, and to S_DATA otherwise.
REQ-019 SHALL, in S_DATA, shift accepted bytes into a 32-bit assembly register and go to S_WRITE on the 4th byte.
REQ-020 SHALL, in S_WRITE, hold imem_w_ena=1 for exactly one cycle with imem_w_addr equal to the word index (0..N-1) and imem_w_data equal to the assembled word.
REQ-021 SHALL increment the word index after each S_WRITE, going to S_CHECK after word N-1 and to S_DATA otherwise.
REQ-022 SHALL keep imem_w_ena=0 in every state other than S_WRITE.
REQ-023 SHALL keep a running 8-bit XOR over all accepted bytes, including both count bytes and excluding the checksum byte.
REQ-024 SHALL, in S_CHECK on an accepted byte, go to S_DONE if the byte equals the running XOR and to S_ERROR otherwise.
REQ-025 SHALL treat S_DONE and S_ERROR as terminal; they are left only by reset.
REQ-026 SHALL use registered outputs only, giving the following timing:
  - done=1 and cpu_reset_n=1 from the first cycle in S_DONE;
  - error=1 from the first cycle in S_ERROR;
  - cpu_reset_n=0 in every other state.
REQ-027 SHALL ignore byte_in whenever byte_valid=0, so that idle gaps of any length between bytes do not change state.

Reset
REQ-028 SHALL, on assertion of reset, asynchronously force the following, even mid-load:
  - state to S_CNT_HI;
  - word index, assembly register and checksum to 0;
  - imem_w_ena, done and error to 0;
  - cpu_reset_n to 0;
  - imem_w_addr and imem_w_data to 0.
REQ-029 SHALL leave words written before a mid-load reset in instruction memory; the next load overwrites them.

Structure
REQ-030 SHALL take the state encoding (3-bit constants) and the count field width (16) from the shared MIPS package; MAX_WORDS stays a module parameter.
REQ-031 SHALL be a single module; the one natural sub-module is the byte-to-word assembler, byte_packer.
REQ-032 SHALL compute the checksum, the N > MAX_WORDS compare and the index counter in-module.

Verification
REQ-033 SHALL cover a two-word load:
  - stream 00 02 20 08 00 05 00 00 00 00 2F;
  - required: writes (addr 0, data 0x20080005) then (addr 1, data 0x00000000);
  - required: done=1, cpu_reset_n=1, error=0.
REQ-034 SHALL cover a bad checksum: the same stream with last byte 0x2E -> both writes occur, error=1, done=0, cpu_reset_n stays 0.
REQ-035 SHALL cover an empty program: stream 00 00 00 -> no imem_w_ena pulse, done=1.
REQ-036 SHALL cover an oversize count: stream 01 2C (N=300) -> error=1 right after the 2nd byte, no writes, byte_ready=0 afterwards.
REQ-037 SHALL cover random byte_valid gaps (0-5 idle cycles) on the two-word stream -> identical writes and done, byte_ready low during each S_WRITE cycle.
REQ-038 SHALL cover reset mid-load:
  - stimulus: reset pulsed after 6 bytes of the two-word stream;
  - required: all outputs return to reset values;
  - required: a full resend then gives done=1.
